// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core: datapath widths, PC increment and fetch FSM states.
package cpu_pkg;

   localparam int XLEN    = 32;
   localparam int INST_W  = 32;
   localparam int PC_STEP = 4;

   typedef enum logic {
      FETCH,
      FLUSH
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} records; head is read straight from registers.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       pushData_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   headValid_o,
   output logic [WIDTH-1:0]       headData_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic             doPush;
   logic             doPop;

   assign doPush      = push_i && !flush_i;
   assign doPop       = pop_i && (count_q != '0) && !flush_i;
   assign count_o     = count_q;
   assign headValid_o = (count_q != '0);
   assign headData_o  = headValid_o ? mem_q[rdPtr_q] : '0;

   // A flush wins over push/pop; a pop in the flush cycle is already consumed by the reader.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q <= count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      doPush |-> (count_q < (PTR_W+1)'(DEPTH)) || doPop);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, in-order memory requests, instruction queue and redirect flush.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_resp_valid,
   input  logic [INST_W-1:0]  imem_resp_data,
   input  logic               redirect,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               inst_valid,
   output logic [INST_W-1:0]  inst,
   output logic [XLEN-1:0]    inst_pc,
   input  logic               inst_ready
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t             state_q;
   logic [XLEN-1:0]          fetchPc_q;
   logic [XLEN-1:0]          respPc_q;
   logic [CNT_W-1:0]         outstanding_q;
   logic [CNT_W-1:0]         outstanding_d;
   logic [CNT_W-1:0]         drop_q;
   logic [CNT_W-1:0]         queueCount;
   logic [CNT_W:0]           inFlight;
   logic                     reqFire;
   logic                     push;
   logic                     pop;
   logic                     headValid;
   logic [XLEN+INST_W-1:0]   headData;
   logic [XLEN-1:0]          redirectTarget;

   // Queued plus outstanding words never exceed DEPTH, so a response always has a free slot.
   assign inFlight       = {1'b0, queueCount} + {1'b0, outstanding_q};
   assign imem_req_valid = rst && (state_q == FETCH) && (inFlight < (CNT_W+1)'(DEPTH)) && !redirect;
   assign imem_req_addr  = fetchPc_q;
   assign reqFire        = imem_req_valid && imem_req_ready;
   assign push           = imem_resp_valid && (state_q == FETCH) && !redirect;
   assign pop            = headValid && inst_ready;
   assign outstanding_d  = outstanding_q + CNT_W'(reqFire) - CNT_W'(imem_resp_valid);
   assign redirectTarget = redirect_pc & ~XLEN'(3);

   assign inst_valid = headValid;
   assign inst       = headData[INST_W-1:0];
   assign inst_pc    = headData[XLEN+INST_W-1:INST_W];

   // Responses still owed after a redirect belong to the old stream and are counted off in FLUSH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= FETCH;
         fetchPc_q     <= RESET_PC;
         respPc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         if (redirect) begin
            fetchPc_q <= redirectTarget;
            respPc_q  <= redirectTarget;
            drop_q    <= outstanding_d;
            state_q   <= (outstanding_d != '0) ? FLUSH : FETCH;
         end else begin
            if (reqFire) fetchPc_q <= fetchPc_q + XLEN'(PC_STEP);
            if (push)    respPc_q  <= respPc_q + XLEN'(PC_STEP);
            if ((state_q == FLUSH) && imem_resp_valid) begin
               drop_q <= drop_q - CNT_W'(1);
               if (drop_q == CNT_W'(1)) state_q <= FETCH;
            end
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN + INST_W)
   ) u_queue (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (push),
      .pushData_i  ({respPc_q, imem_resp_data}),
      .pop_i       (pop),
      .flush_i     (redirect),
      .count_o     (queueCount),
      .headValid_o (headValid),
      .headData_o  (headData)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and a randomized run
// against a queue-based model of the instruction stream and an in-order memory.
module tb_fetch_unit;

   localparam int DEPTH = 4;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int nCompared = 0;
   int nMismatch = 0;

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          reqReady;
      bit          respValid;
      logic [31:0] respData;
      bit          redir;
      logic [31:0] redirPc;
      bit          instReady;
      bit          expReqValid;
      logic [31:0] expReqAddr;
      bit          expInstValid;
      logic [31:0] expInstPc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } memReq_t;

   vec_t        vecs[$];
   memReq_t     pending[$];
   logic [31:0] modelQ[$];
   logic [31:0] modelPc;
   int          cyc;
   int          dutIssued;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(input bit rr, input bit rv, input logic [31:0] rd, input bit rdr,
                               input logic [31:0] rpc, input bit ir, input bit ev,
                               input logic [31:0] ea, input bit eiv, input logic [31:0] eipc);
      vec_t v;
      v.reqReady = rr; v.respValid = rv; v.respData = rd; v.redir = rdr; v.redirPc = rpc;
      v.instReady = ir; v.expReqValid = ev; v.expReqAddr = ea; v.expInstValid = eiv;
      v.expInstPc = eipc;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rr, input bit rv, input logic [31:0] rd, input bit rdr,
                                input logic [31:0] rpc, input bit ir);
      imem_req_ready  = rr;
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      redirect        = rdr;
      redirect_pc     = rpc;
      inst_ready      = ir;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      checkOutput({tag, "_req_addr"}, imem_req_addr, 32'h0);
      checkOutput({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      checkOutput({tag, "_inst"}, inst, 32'h0);
      checkOutput({tag, "_inst_pc"}, inst_pc, 32'h0);
   endtask

   // Leaves the bench at #1 after a rising edge with rst released and the model empty.
   task automatic resetDut();
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      pending.delete();
      modelQ.delete();
      modelPc = 32'h0;
      cyc = 0;
   endtask

   // One clock of the reference model: memory answers in order once its latency has elapsed,
   // words requested before a redirect never reach the consumer, and a new request is allowed
   // only while the old stream is fully drained and queued plus outstanding words stay below DEPTH.
   task automatic modelCycle(input bit reqRdy, input bit instRdy, input bit redir,
                             input logic [31:0] redirPc, input int lat);
      bit      expReqValid;
      bit      respNow;
      bit      stalePending;
      memReq_t r;
      respNow = (pending.size() > 0) && (pending[0].due <= cyc);
      applyStimulus(reqRdy, respNow, respNow ? memWord(pending[0].addr) : JUNK, redir, redirPc, instRdy);
      stalePending = 1'b0;
      foreach (pending[i]) if (pending[i].stale) stalePending = 1'b1;
      expReqValid = !redir && !stalePending && ((modelQ.size() + pending.size()) < DEPTH);
      @(negedge clk);
      checkOutput("req_valid", 32'(imem_req_valid), 32'(expReqValid));
      if (expReqValid) checkOutput("req_addr", imem_req_addr, modelPc);
      checkOutput("inst_valid", 32'(inst_valid), 32'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         checkOutput("inst_pc", inst_pc, modelQ[0]);
         checkOutput("inst", inst, memWord(modelQ[0]));
      end
      if (imem_req_valid && reqRdy) dutIssued++;
      @(posedge clk);
      if ((modelQ.size() > 0) && instRdy) void'(modelQ.pop_front());
      if (respNow) begin
         r = pending.pop_front();
         if (!r.stale && !redir) modelQ.push_back(r.addr);
      end
      if (expReqValid && reqRdy) begin
         r.addr  = modelPc;
         r.due   = cyc + lat;
         r.stale = 1'b0;
         pending.push_back(r);
         modelPc = modelPc + 32'd4;
      end
      if (redir) begin
         modelQ.delete();
         foreach (pending[i]) pending[i].stale = 1'b1;
         modelPc = redirPc & ~32'h3;
      end
      cyc++;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
      #1;
      checkResetValues("async_reset");

      // Streaming with 1-cycle memory, a redirect with two words owed, and a redirect that
      // coincides with a dequeue and a response.
      vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,   1, 1, 32'h000, 0, 32'h0));
      vecs.push_back(mk(1, 1, memWord(32'h0), 0, 32'h0,   1, 1, 32'h004, 0, 32'h0));
      vecs.push_back(mk(1, 1, memWord(32'h4), 0, 32'h0,   1, 1, 32'h008, 1, 32'h000));
      vecs.push_back(mk(1, 1, memWord(32'h8), 0, 32'h0,   1, 1, 32'h00C, 1, 32'h004));
      vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,   0, 1, 32'h010, 1, 32'h008));
      vecs.push_back(mk(1, 0, 32'h0,          1, 32'h103, 0, 0, 32'h014, 1, 32'h008));
      vecs.push_back(mk(1, 1, JUNK,           0, 32'h0,   0, 0, 32'h100, 0, 32'h0));
      vecs.push_back(mk(1, 1, JUNK,           0, 32'h0,   0, 0, 32'h100, 0, 32'h0));
      vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,   1, 1, 32'h100, 0, 32'h0));
      vecs.push_back(mk(1, 1, memWord(32'h100), 0, 32'h0, 1, 1, 32'h104, 0, 32'h0));
      vecs.push_back(mk(1, 1, memWord(32'h104), 0, 32'h0, 1, 1, 32'h108, 1, 32'h100));
      vecs.push_back(mk(1, 1, memWord(32'h108), 1, 32'h200, 1, 0, 32'h10C, 1, 32'h104));
      vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,   1, 1, 32'h200, 0, 32'h0));

      resetDut();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].reqReady, vecs[i].respValid, vecs[i].respData, vecs[i].redir,
                       vecs[i].redirPc, vecs[i].instReady);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].expReqValid));
         checkOutput($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].expReqAddr);
         checkOutput($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].expInstValid));
         if (vecs[i].expInstValid) begin
            checkOutput($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].expInstPc);
            checkOutput($sformatf("vec%0d_inst", i), inst, memWord(vecs[i].expInstPc));
         end
         @(posedge clk);
         #1;
      end

      // Consumer stalled: exactly DEPTH requests go out, then the queue drains in order.
      resetDut();
      dutIssued = 0;
      for (int i = 0; i < 10; i++) modelCycle(1, 0, 0, 32'h0, 1);
      checkOutput("fill_requests", 32'(dutIssued), 32'(DEPTH));
      for (int i = 0; i < 10; i++) modelCycle(1, 1, 0, 32'h0, 1);

      // Memory not ready: the request address holds at 0x8.
      resetDut();
      modelCycle(1, 1, 0, 32'h0, 1);
      modelCycle(1, 1, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) begin
         modelCycle(0, 1, 0, 32'h0, 1);
         checkOutput("hold_addr", imem_req_addr, 32'h8);
      end
      for (int i = 0; i < 4; i++) modelCycle(1, 1, 0, 32'h0, 1);

      // PC wraps from the top of the address space.
      for (int i = 0; i < 4; i++) modelCycle(0, 1, 0, 32'h0, 1);
      modelCycle(0, 1, 1, 32'hFFFF_FFFE, 1);
      checkOutput("wrap_first", imem_req_addr, 32'hFFFF_FFFC);
      modelCycle(1, 1, 0, 32'h0, 1);
      checkOutput("wrap_next", imem_req_addr, 32'h0000_0000);
      for (int i = 0; i < 4; i++) modelCycle(1, 1, 0, 32'h0, 1);

      // Randomized traffic with varying latency, back-pressure and redirects.
      resetDut();
      for (int i = 0; i < 600; i++) begin
         modelCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom(), int'($urandom_range(1, 3)));
      end

      // Reset asserted mid-stream with a full queue clears the outputs at once.
      resetDut();
      for (int i = 0; i < 8; i++) modelCycle(1, 0, 0, 32'h0, 1);
      checkOutput("pre_reset_inst_valid", 32'(inst_valid), 32'd1);
      #3;
      rst = 1'b0;
      #1;
      checkResetValues("midreset");
      resetDut();
      for (int i = 0; i < 6; i++) modelCycle(1, 1, 0, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the cpu core: owns the program counter, issues in-order word requests to instruction memory, buffers returned words in a small queue and presents them with their PC to the decoder's 32-bit instruction input over a valid/ready handshake. It is the producer side of the instruction stream the core consumes, and accepts a redirect (branch/jump target) that flushes in-flight and buffered instructions.

## Interface
- DEPTH, 4: instruction queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  word-aligned fetch address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction word returned (in request order, ≥1 cycle after acceptance)
- imem_resp_data  in  32  returned instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] ignored (forced 0)
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction (to decoder `in`)
- inst_pc  out  32  PC of queue head
- inst_ready  in  1  consumer takes head this cycle

## Operation
- Registers: fetch_pc, resp_pc, outstanding (0..DEPTH), drop (0..DEPTH), queue count, state.
- States: FETCH, FLUSH.
- Issue rule (FETCH only): imem_req_valid = (count + outstanding < DEPTH) && !redirect; no combinational path from inst_ready or imem_req_ready to imem_req_valid.
- Request accept (valid && ready): fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response in FETCH: push {imem_resp_data, resp_pc}; resp_pc += 4; outstanding -= 1. Overflow is impossible by issue rule; assertion required.
- Response in FLUSH: discarded; drop -= 1, outstanding -= 1.
- Dequeue on inst_valid && inst_ready.
- Redirect (any state), at the edge: queue emptied (a dequeue in the same cycle still completes); fetch_pc and resp_pc ← {redirect_pc[31:2],2'b00}; a response arriving in that cycle is discarded; drop ← outstanding remaining after that cycle's response; state ← FLUSH if that drop > 0, else FETCH.
- FLUSH → FETCH on the edge where drop reaches 0; first new request can be valid the next cycle.
- Back-to-back redirects: last one wins; drop accumulates correctly.

## Timing
- Reset (rst low, asynchronous): imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, state FETCH, all counters 0, fetch_pc = resp_pc = RESET_PC.
- First cycle after rst deasserts: imem_req_valid 1, addr RESET_PC.
- Enqueue → inst_valid: 1 cycle (registered queue outputs); response at edge N gives inst_valid during cycle N+1.
- With 1-cycle memory and DEPTH ≥ 3 and inst_ready held high: sustained 1 instruction/cycle.
- imem_req_addr = fetch_pc; held stable while valid && !ready.
- inst/inst_pc held stable while inst_valid && !inst_ready.
- Reset asserted mid-burst: all state cleared immediately; late memory responses after reset are the memory's responsibility to suppress.

## Structure
- Shared package cpu_pkg: XLEN = 32, INST_W = 32, PC_STEP = 4, fetch_state_t enum {FETCH, FLUSH}.
- Sub-module fetch_queue: synchronous FIFO, width 64 ({pc, inst}), DEPTH entries, push/pop/flush, count output, registered head.

## Test plan
- Reset release, 1-cycle memory, inst_ready=1 → requests 0x0,0x4,0x8,… on consecutive cycles; inst_valid from cycle 3; inst_pc matches each word.
- inst_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, queue fills to 4, then imem_req_valid stays 0; releasing ready drains in order, no loss.
- imem_req_ready low 3 cycles → imem_req_addr held at 0x8, no PC advance.
- Redirect to 0x103 with 2 requests outstanding → both responses dropped, next request addr 0x100, first inst_pc 0x100, state FLUSH for 2 cycles.
- Redirect coincident with dequeue and a response → dequeued word delivered, response discarded, queue empty next cycle.
- fetch_pc at 0xFFFF_FFFC → next request 0x0000_0000; rst pulsed mid-stream → outputs return to reset values same cycle.
